// File: rtl/iq_byte_deinterleave.sv
// rtl/iq_byte_deinterleave.sv - byte-stream I/Q deinterleaver and quantizer (optional IQ_CONJ_EN conjugates Q)
module iq_byte_deinterleave #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int QUANT_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [BYTE_WIDTH-1:0] in_dout,
    output logic [DATA_WIDTH-1:0] i_out,
    output logic                  i_wr_en,
    input  logic                  i_full,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  q_wr_en,
    input  logic                  q_full
);

    typedef enum logic [2:0] {
        S_I_LO,
        S_I_HI,
        S_Q_LO,
        S_Q_HI,
        S_WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [BYTE_WIDTH-1:0] i_lo_q, i_lo_d;
    logic [BYTE_WIDTH-1:0] i_hi_q, i_hi_d;
    logic [BYTE_WIDTH-1:0] q_lo_q, q_lo_d;
    logic [BYTE_WIDTH-1:0] q_hi_q, q_hi_d;
    logic [DATA_WIDTH-1:0] i_quant;
    logic [DATA_WIDTH-1:0] q_quant;
    logic [DATA_WIDTH-1:0] q_sel;

    function automatic logic [DATA_WIDTH-1:0] quantize(input logic [15:0] s);
        logic [DATA_WIDTH-1:0] ext;
        ext = {{(DATA_WIDTH-16){s[15]}}, s};
        return ext << QUANT_BITS;
    endfunction

    assign i_quant = quantize({i_hi_q, i_lo_q});
    assign q_quant = quantize({q_hi_q, q_lo_q});

`ifdef IQ_CONJ_EN
    assign q_sel = -q_quant;
`else
    assign q_sel = q_quant;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_I_LO;
            i_lo_q  <= '0;
            i_hi_q  <= '0;
            q_lo_q  <= '0;
            q_hi_q  <= '0;
        end else begin
            state_q <= state_d;
            i_lo_q  <= i_lo_d;
            i_hi_q  <= i_hi_d;
            q_lo_q  <= q_lo_d;
            q_hi_q  <= q_hi_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        i_lo_d   = i_lo_q;
        i_hi_d   = i_hi_q;
        q_lo_d   = q_lo_q;
        q_hi_d   = q_hi_q;
        in_rd_en = 1'b0;
        i_wr_en  = 1'b0;
        q_wr_en  = 1'b0;
        i_out    = '0;
        q_out    = '0;
        // Strobes stay quiet while reset is held so no byte is lost during it.
        if (!rst) begin
            case (state_q)
                S_I_LO: if (!in_empty) begin
                    in_rd_en = 1'b1;
                    i_lo_d   = in_dout;
                    state_d  = S_I_HI;
                end
                S_I_HI: if (!in_empty) begin
                    in_rd_en = 1'b1;
                    i_hi_d   = in_dout;
                    state_d  = S_Q_LO;
                end
                S_Q_LO: if (!in_empty) begin
                    in_rd_en = 1'b1;
                    q_lo_d   = in_dout;
                    state_d  = S_Q_HI;
                end
                S_Q_HI: if (!in_empty) begin
                    in_rd_en = 1'b1;
                    q_hi_d   = in_dout;
                    state_d  = S_WRITE;
                end
                S_WRITE: if (!i_full && !q_full) begin
                    i_wr_en = 1'b1;
                    q_wr_en = 1'b1;
                    i_out   = i_quant;
                    q_out   = q_sel;
                    state_d = S_I_LO;
                end
                default: state_d = S_I_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_byte_deinterleave.sv
// tb/tb_iq_byte_deinterleave.sv - scoreboard bench for iq_byte_deinterleave (honours IQ_CONJ_EN)
module tb_iq_byte_deinterleave;

    logic        clk;
    logic        rst;
    logic        in_rd_en;
    logic        in_empty;
    logic [7:0]  in_dout;
    logic [31:0] i_out;
    logic        i_wr_en;
    logic        i_full;
    logic [31:0] q_out;
    logic        q_wr_en;
    logic        q_full;

    iq_byte_deinterleave dut (
        .clk      (clk),
        .rst      (rst),
        .in_rd_en (in_rd_en),
        .in_empty (in_empty),
        .in_dout  (in_dout),
        .i_out    (i_out),
        .i_wr_en  (i_wr_en),
        .i_full   (i_full),
        .q_out    (q_out),
        .q_wr_en  (q_wr_en),
        .q_full   (q_full)
    );

    logic [7:0]  byte_q[$];
    logic [63:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int pops = 0;
    int wr_count = 0;
    int i_wr_count = 0;
    int q_wr_count = 0;
    int first_rd_cyc = -1;
    int first_wr_cyc = -1;
    int first_wr_pops = -1;
    int gap_at = -1;
    int gap_len = 0;
    int gap_cnt = 0;
    int qf_at = -1;
    int qf_len = 0;
    int qf_cnt = 0;
    bit rand_mode = 0;
    bit rd_fire;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] quant(input logic [15:0] s);
        logic signed [31:0] v;
        v = $signed(s);
        return v <<< 10;
    endfunction

    task automatic push_pair(input logic [15:0] iv, input logic [15:0] qv);
        logic [31:0] qe;
        qe = quant(qv);
`ifdef IQ_CONJ_EN
        qe = -qe;
`endif
        byte_q.push_back(iv[7:0]);
        byte_q.push_back(iv[15:8]);
        byte_q.push_back(qv[7:0]);
        byte_q.push_back(qv[15:8]);
        exp_q.push_back({quant(iv), qe});
    endtask

    task automatic begin_scn();
        pops = 0;
        wr_count = 0;
        first_rd_cyc = -1;
        first_wr_cyc = -1;
        first_wr_pops = -1;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n;
        n = 0;
        while (wr_count < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("wr_timeout", 64'(wr_count >= target), 64'd1);
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // FIFO models, throttling and output monitor share one process to keep ordering fixed.
    initial begin
        logic [63:0] e;
        in_empty = 1;
        in_dout  = 0;
        i_full   = 0;
        q_full   = 0;
        forever begin
            @(negedge clk);
            rd_fire = in_rd_en && !in_empty;
            if (in_rd_en) check("rd_when_empty", 64'(in_empty), 64'd0);
            if (rd_fire && first_rd_cyc < 0) first_rd_cyc = cyc;
            if (i_wr_en || q_wr_en) begin
                check("wr_pair", 64'(i_wr_en), 64'(q_wr_en));
                check("wr_when_full", 64'((i_wr_en && i_full) || (q_wr_en && q_full)), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("i_out", 64'(i_out), 64'(e[63:32]));
                    check("q_out", 64'(q_out), 64'(e[31:0]));
                end
                if (first_wr_cyc < 0) begin
                    first_wr_cyc  = cyc;
                    first_wr_pops = pops;
                end
                wr_count++;
            end else begin
                check("idle_out_zero", {i_out, q_out}, 64'd0);
            end
            if (i_wr_en) i_wr_count++;
            if (q_wr_en) q_wr_count++;
            @(posedge clk);
            #1;
            cyc++;
            if (rd_fire) begin
                void'(byte_q.pop_front());
                pops++;
            end
            if (gap_cnt > 0) gap_cnt--;
            if (rd_fire && pops == gap_at) gap_cnt = gap_len;
            if (qf_cnt > 0) qf_cnt--;
            if (rd_fire && pops == qf_at) qf_cnt = qf_len;
            in_empty = (byte_q.size() == 0) || (gap_cnt > 0) || (rand_mode && $urandom_range(3) == 0);
            in_dout  = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
            i_full   = rand_mode && $urandom_range(4) == 0;
            q_full   = (qf_cnt > 0) || (rand_mode && $urandom_range(4) == 0);
        end
    end

    initial begin
        int n;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", 64'(in_rd_en), 64'd0);
        check("rst_wr_en", 64'({i_wr_en, q_wr_en}), 64'd0);
        check("rst_outs", {i_out, q_out}, 64'd0);
        @(posedge clk);
        #2 rst = 0;

        // Basic pair, unthrottled: write lands in the 5th cycle.
        begin_scn();
        push_pair(16'h1234, 16'h5678);
        wait_wr(1, 50);
        check("lat_basic", 64'(first_wr_cyc - first_rd_cyc), 64'd4);
        repeat (5) @(posedge clk);
        check("count_basic", 64'(wr_count), 64'd1);

        // Sign extremes.
        begin_scn();
        push_pair(16'h8000, 16'hFFFF);
        wait_wr(1, 50);
        check("lat_sign", 64'(first_wr_cyc - first_rd_cyc), 64'd4);

        // Three empty cycles between the 2nd and 3rd byte.
        begin_scn();
        gap_at = 2;
        gap_len = 3;
        push_pair(16'h1234, 16'h5678);
        wait_wr(1, 50);
        check("lat_gap", 64'(first_wr_cyc - first_rd_cyc), 64'd7);
        gap_at = -1;
        repeat (3) @(posedge clk);

        // q_full held 4 cycles in S_WRITE; follow-on bytes must not be read meanwhile.
        begin_scn();
        qf_at = 4;
        qf_len = 4;
        push_pair(16'h1234, 16'h5678);
        push_pair(16'h0001, 16'hFFFE);
        wait_wr(2, 100);
        check("lat_qfull", 64'(first_wr_cyc - first_rd_cyc), 64'd8);
        check("pops_qfull", 64'(first_wr_pops), 64'd4);
        qf_at = -1;
        repeat (5) @(posedge clk);
        check("count_qfull", 64'(wr_count), 64'd2);

        // Reset after two bytes of a sample discards them.
        begin_scn();
        byte_q.push_back(8'h34);
        byte_q.push_back(8'h12);
        n = 0;
        while (pops < 2 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("partial_pops", 64'(pops), 64'd2);
        @(posedge clk);
        #2 rst = 1;
        @(posedge clk);
        #2 rst = 0;
        begin_scn();
        push_pair(16'h0011, 16'h0022);
        wait_wr(1, 50);
        repeat (5) @(posedge clk);
        check("count_rst", 64'(wr_count), 64'd1);

        // Random traffic with random empty/full throttling.
        begin_scn();
        rand_mode = 1;
        for (int k = 0; k < 1000; k++) push_pair(16'($urandom), 16'($urandom));
        wait_wr(1000, 30000);
        rand_mode = 0;
        repeat (10) @(posedge clk);
        check("rand_count", 64'(wr_count), 64'd1000);
        check("rand_sb_empty", 64'(exp_q.size()), 64'd0);
        check("iq_counts_equal", 64'(i_wr_count), 64'(q_wr_count));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iq_byte_deinterleave.md
Name: iq_byte_deinterleave

Overview:
- Front-end producer for the complex FIR path.
- Reads a byte stream of interleaved little-endian 16-bit I/Q samples from a single input FIFO.
- Sign-extends and quantizes each component to DATA_WIDTH fixed point (value << QUANT_BITS).
- Writes each I/Q pair, simultaneously, into the separate real and imaginary FIFOs that feed the filter.

Parameters:
- DATA_WIDTH, 32: width of quantized output samples.
- BYTE_WIDTH, 8: input FIFO word width. Fixed at 8; other values are unsupported.
- QUANT_BITS, 10: left shift applied to each sign-extended 16-bit sample. Must satisfy 16 + QUANT_BITS <= DATA_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_rd_en  out  1  pop strobe for the input byte FIFO.
- in_empty  in  1  input FIFO empty.
- in_dout  in  BYTE_WIDTH  input FIFO head data (first-word-fall-through, valid while !in_empty).
- i_out  out  DATA_WIDTH  quantized I sample, signed.
- i_wr_en  out  1  push strobe for the I FIFO.
- i_full  in  1  I FIFO full.
- q_out  out  DATA_WIDTH  quantized Q sample, signed.
- q_wr_en  out  1  push strobe for the Q FIFO.
- q_full  in  1  Q FIFO full.

Behaviour:
- Reset (async, active-high):
  - state = S_I_LO.
  - Byte registers i_lo, i_hi, q_lo, q_hi = 0.
  - in_rd_en, i_wr_en, q_wr_en = 0.
  - i_out, q_out = 0.
- Byte order per sample: I[7:0], I[15:8], Q[7:0], Q[15:8].
- FSM states: S_I_LO, S_I_HI, S_Q_LO, S_Q_HI, S_WRITE.
- Byte states (S_I_LO..S_Q_HI):
  - If !in_empty: in_rd_en = 1 combinationally in the same cycle; in_dout is captured into the matching byte register at the clock edge; state advances to the next state.
  - If in_empty: in_rd_en = 0, state holds, registers hold.
  - S_Q_HI advances to S_WRITE.
- S_WRITE:
  - If !i_full && !q_full: i_wr_en = q_wr_en = 1 in the same cycle; i_out and q_out are driven with the quantized values; state goes to S_I_LO.
  - If either FIFO is full: neither wr_en asserts and state holds. The I and Q writes are never split.
  - No input reads occur in S_WRITE.
- Outputs: i_out/q_out are combinational, nonzero only while wr_en is high, 0 otherwise.
  - in_rd_en never asserts while in_empty = 1.
  - wr_en never asserts while the corresponding full = 1.
- Arithmetic:
  - Form s = signed {hi, lo} (16 bits).
  - Sign-extend s to DATA_WIDTH.
  - Arithmetic shift left by QUANT_BITS; truncate to DATA_WIDTH. No saturation is needed given the parameter constraint.
- Throughput/latency:
  - Minimum 5 cycles per sample pair.
  - Write occurs 1 cycle after the edge that captures the Q high byte.
  - Each empty or full stall cycle adds exactly 1 cycle.
- Reset mid-sample: partially assembled bytes are discarded. After reset release, the next byte read is treated as I[7:0].
- in_empty deasserting in the same cycle as a state change: the FSM samples inputs only in the current state, with no look-ahead.

Optional Feature:
- Macro: IQ_CONJ_EN.
  - Defined: q_out = two's-complement negation of the quantized Q, wrapping in DATA_WIDTH. This delivers the complex conjugate for spectrum-inverted tuners.
  - Undefined: q_out = quantized Q unchanged.
- i_out, timing and handshakes are identical in both builds.

Test Plan:
- Bytes 0x34,0x12,0x78,0x56 with the input FIFO always non-empty and outputs never full -> exactly one write 5 cycles after the first read; i_out = 0x0048D000, q_out = 0x0159E000.
- Bytes 0x00,0x80,0xFF,0xFF -> i_out = 0xFE000000, q_out = 0xFFFFFC00. With IQ_CONJ_EN defined, q_out = 0x00000400.
- in_empty high for 3 cycles between the 2nd and 3rd byte -> in_rd_en low during the gap, no byte skipped, write occurs 8 cycles after the first read, values as in the first scenario.
- q_full high for 4 cycles while in S_WRITE -> i_wr_en and q_wr_en both stay low and in_rd_en stays low. Both wr_en pulse for exactly 1 cycle the cycle q_full drops.
- rst pulsed after 2 bytes (0x34, 0x12) of a sample, then stream 0x11,0x00,0x22,0x00 -> single write with i_out = 0x00004400, q_out = 0x00008800; no stale 0x1234 appears.
- 1000 random sample pairs with random empty/full throttling -> output sequence matches the reference model bit-exactly; the I and Q write counts are always equal.
